// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: default widths and the per-bit debounce state encoding.
package gpio_pkg;
  localparam int GPIO_W_DEF   = 8;
  localparam int DB_CNT_W_DEF = 16;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;
endpackage

// File: rtl/gpio_db_bit.sv
// One pad bit: two-flop synchroniser, debounce counter, stable level and edge pulses.
module gpio_db_bit
  import gpio_pkg::*;
#(
  parameter int CNT_W = DB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pad,
  input  logic             db_en,
  input  logic [CNT_W-1:0] db_lim,
  output logic             st,
  output logic             rise,
  output logic             fall
);
  logic             s1_q, s2_q;
  logic             st_q, st_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state;

  // State is implicit: pending whenever the synchronised level disagrees with st.
  assign state = (s2_q == st_q) ? DB_STABLE : DB_PENDING;

  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    if (!db_en) begin
      st_d = s2_q;
    end else begin
      case (state)
        DB_STABLE: ;
        DB_PENDING: begin
          // >= so a lowered limit accepts at once and the counter never wraps
          if (cnt_q >= db_lim) st_d  = s2_q;
          else                 cnt_d = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
    rise_d = ~st_q &  st_d;
    fall_d =  st_q & ~st_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      st_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= pad;
      s2_q   <= s1_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign st   = st_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/gpio_db.sv
// GPIO input conditioning: independent synchronise + debounce + edge detect per pad bit.
module gpio_db
  import gpio_pkg::*;
#(
  parameter int gpio_w = GPIO_W_DEF,
  parameter int cnt_w  = DB_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [gpio_w-1:0] pad_in,
  input  logic              db_en,
  input  logic [cnt_w-1:0]  db_lim,
  output logic [gpio_w-1:0] gpi_out,
  output logic [gpio_w-1:0] rise,
  output logic [gpio_w-1:0] fall
);
  for (genvar i = 0; i < gpio_w; i++) begin : g_bit
    gpio_db_bit #(
      .CNT_W (cnt_w)
    ) u_bit (
      .clk    (clk),
      .rstn   (rstn),
      .pad    (pad_in[i]),
      .db_en  (db_en),
      .db_lim (db_lim),
      .st     (gpi_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end
endmodule

// File: tb/tb_gpio_db.sv
// Directed bench for gpio_db: bypass vector table plus hand-timed debounce sequences.
module tb_gpio_db;
  logic        clk;
  logic        rstn;
  logic [7:0]  pad_in;
  logic        db_en;
  logic [15:0] db_lim;
  logic [7:0]  gpi_out, rise, fall;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] gpi;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t tbl [20];

  gpio_db dut (
    .clk     (clk),
    .rstn    (rstn),
    .pad_in  (pad_in),
    .db_en   (db_en),
    .db_lim  (db_lim),
    .gpi_out (gpi_out),
    .rise    (rise),
    .fall    (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance one edge, sample at the following negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("rise_fall_excl", rise & fall, 8'h00);
  endtask

  // pat[s-1] drives pad_in[b] before edge s; er/ef = step of the expected pulse (0 = none)
  task automatic run_bit(input string nm, input int b, input logic [63:0] pat,
                         input int n, input int er, input int ef);
    for (int s = 1; s <= n; s++) begin
      pad_in[b] = pat[s-1];
      step();
      chk({nm, "_rise"}, {7'b0, rise[b]}, {7'b0, (s == er)});
      chk({nm, "_fall"}, {7'b0, fall[b]}, {7'b0, (s == ef)});
    end
  endtask

  initial begin
    // bypass: pad[0] toggles every 5 cycles, pad[7] gets a 1-cycle pulse; 2-row lag
    tbl[0]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{8'h81, 8'h01, 8'h01, 8'h00};
    tbl[3]  = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[4]  = '{8'h01, 8'h81, 8'h80, 8'h00};
    tbl[5]  = '{8'h00, 8'h01, 8'h00, 8'h80};
    tbl[6]  = '{8'h00, 8'h01, 8'h00, 8'h00};
    tbl[7]  = '{8'h00, 8'h00, 8'h00, 8'h01};
    tbl[8]  = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{8'h01, 8'h01, 8'h01, 8'h00};
    tbl[13] = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[14] = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[15] = '{8'h00, 8'h01, 8'h00, 8'h00};
    tbl[16] = '{8'h00, 8'h01, 8'h00, 8'h00};
    tbl[17] = '{8'h00, 8'h00, 8'h00, 8'h01};
    tbl[18] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[19] = '{8'h00, 8'h00, 8'h00, 8'h00};

    // reset with all pads high, then full debounce (lim 4 -> 7 edges)
    rstn = 1'b0; pad_in = 8'hFF; db_en = 1'b1; db_lim = 16'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gpi", gpi_out, 8'h00);
      chk("rst_rise", rise, 8'h00);
      chk("rst_fall", fall, 8'h00);
    end
    rstn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("rel_gpi", gpi_out, (e >= 7) ? 8'hFF : 8'h00);
      chk("rel_rise", rise, (e == 7) ? 8'hFF : 8'h00);
      chk("rel_fall", fall, 8'h00);
    end

    // bypass table
    db_en = 1'b0; pad_in = 8'h00;
    for (int i = 0; i < 4; i++) step();
    chk("byp_pre_gpi", gpi_out, 8'h00);
    for (int i = 0; i < 20; i++) begin
      pad_in = tbl[i].pad;
      step();
      chk($sformatf("byp%0d_gpi", i), gpi_out, tbl[i].gpi);
      chk($sformatf("byp%0d_rise", i), rise, tbl[i].rise);
      chk($sformatf("byp%0d_fall", i), fall, tbl[i].fall);
    end

    // glitch reject: 10-cycle pulse dropped, 11-cycle pulse accepted at edge 13
    db_en = 1'b1; db_lim = 16'd10;
    run_bit("glitch10", 3, 64'h3FF, 30, 0, 0);
    chk("glitch10_gpi", gpi_out, 8'h00);
    run_bit("glitch11", 3, 64'h7FF, 35, 13, 24);
    chk("glitch11_gpi", gpi_out, 8'h00);

    // bounce on bit 5: final rise seen at edge 11, accepted 10 edges later
    db_lim = 16'd8;
    run_bit("bounce", 5, 64'hFFFF_FFFF_FFFF_FDE7, 30, 21, 0);
    chk("bounce_gpi", gpi_out, 8'h20);

    // independence: bit 1 up and bit 6 down together, lim 2 -> edge 5
    db_lim = 16'd2; pad_in = 8'h60;
    for (int i = 0; i < 8; i++) step();
    chk("ind_pre_gpi", gpi_out, 8'h60);
    pad_in = 8'h22;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk("ind_gpi", gpi_out, (s >= 5) ? 8'h22 : 8'h60);
      chk("ind_rise", rise, (s == 5) ? 8'h02 : 8'h00);
      chk("ind_fall", fall, (s == 5) ? 8'h40 : 8'h00);
    end

    // limit lowered below a running count of 7 -> accepted on the next edge
    db_lim = 16'd20; pad_in = 8'h26;
    for (int s = 1; s <= 9; s++) begin
      step();
      chk("lim_hold_gpi", gpi_out, 8'h22);
      chk("lim_hold_rise", rise, 8'h00);
    end
    db_lim = 16'd3;
    step();
    chk("lim_acc_gpi", gpi_out, 8'h26);
    chk("lim_acc_rise", rise, 8'h04);
    step();
    chk("lim_after_rise", rise, 8'h00);

    // reset while falls are pending: everything clears, no pulses afterwards
    db_lim = 16'd10; pad_in = 8'h00;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk("rm_pend_gpi", gpi_out, 8'h26);
    end
    rstn = 1'b0;
    #1;
    chk("rm_async_gpi", gpi_out, 8'h00);
    chk("rm_async_rise", rise, 8'h00);
    chk("rm_async_fall", fall, 8'h00);
    step(); step();
    chk("rm_hold_gpi", gpi_out, 8'h00);
    rstn = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      step();
      chk("rm_post_gpi", gpi_out, 8'h00);
      chk("rm_post_rise", rise, 8'h00);
      chk("rm_post_fall", fall, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
